// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and constants for the single-port memory request interface
package mem_if_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);
    localparam int DEF_TIMEOUT    = 8;

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0]      wdata;
    } mem_req_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_init_timeout.sv
// mem_init_timeout: loadable down-counter; expired is high once the count reaches zero
module mem_init_timeout #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic res,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // load arms a full window of TIMEOUT wait cycles; dec counts one of them down
    always_ff @(posedge clk) begin
        if (res)
            cnt <= '0;
        else if (load)
            cnt <= CW'(TIMEOUT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: one-at-a-time memory initiator; MEM_INITIATOR_STATS_EN enables the stat_* counters
module mem_initiator
#(
    parameter int WIDTH      = mem_if_pkg::DEF_WIDTH,
    parameter int DEPTH      = mem_if_pkg::DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = mem_if_pkg::DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic [15:0]           stat_rd,
    output logic [15:0]           stat_wr,
    output logic [15:0]           stat_err
);

    import mem_if_pkg::*;

    state_t                state, state_n;
    logic                  mv_n, mwr_n, rv_n, rwr_n, rerr_n;
    logic [ADDR_WIDTH-1:0] maddr_n;
    logic [WIDTH-1:0]      mwd_n, rd_n;
    logic                  load, dec, expired;

    mem_init_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .res     (res),
        .load    (load),
        .dec     (dec),
        .expired (expired)
    );

    assign req_ready = (state == IDLE);

    // next state and next value of every registered output; everything holds by default
    always_comb begin
        state_n = state;
        mv_n    = 1'b0;
        mwr_n   = mem_wr_rd;
        maddr_n = mem_addr;
        mwd_n   = mem_wdata;
        rv_n    = rsp_valid;
        rwr_n   = rsp_wr;
        rd_n    = rsp_rdata;
        rerr_n  = rsp_err;
        load    = 1'b0;
        dec     = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_n = ISSUE;
                mv_n    = 1'b1;
                mwr_n   = req_wr;
                maddr_n = req_addr;
                mwd_n   = req_wdata;
            end
            ISSUE: begin
                state_n = WAIT;
                load    = 1'b1;
            end
            WAIT: if (mem_ready) begin
                state_n = RESP;
                rv_n    = 1'b1;
                rwr_n   = mem_wr_rd;
                rerr_n  = 1'b0;
                rd_n    = (mem_wr_rd == MEM_RD) ? mem_rdata : '0;
            end else if (expired) begin
                state_n = RESP;
                rv_n    = 1'b1;
                rwr_n   = mem_wr_rd;
                rerr_n  = 1'b1;
                rd_n    = '0;
            end else begin
                dec = 1'b1;
            end
            RESP: if (rsp_ready) begin
                state_n = IDLE;
                rv_n    = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            mem_valid <= mv_n;
            mem_wr_rd <= mwr_n;
            mem_addr  <= maddr_n;
            mem_wdata <= mwd_n;
            rsp_valid <= rv_n;
            rsp_wr    <= rwr_n;
            rsp_rdata <= rd_n;
            rsp_err   <= rerr_n;
        end
    end

`ifdef MEM_INITIATOR_STATS_EN
    logic hs;

    assign hs = (state == RESP) && rsp_ready;

    // count each completed response by outcome on the response handshake
    always_ff @(posedge clk) begin
        if (res) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else if (hs) begin
            if (rsp_err)
                stat_err <= sat_inc(stat_err);
            else if (rsp_wr)
                stat_wr <= sat_inc(stat_wr);
            else
                stat_rd <= sat_inc(stat_rd);
        end
    end
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized transaction bench with a memory responder and a cycle-timeline model
module tb_mem_initiator;

    localparam int W  = 16;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          req_valid = 1'b0, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          req_ready, mem_valid, mem_wr_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_ready = 1'b0, rsp_ready = 1'b0;
    logic          rsp_valid, rsp_wr, rsp_err;
    logic [W-1:0]  rsp_rdata;
    logic [15:0]   stat_rd, stat_wr, stat_err;

    int checks = 0, failures = 0;
    bit armed = 1'b0;

    logic          e_rr, e_mv, e_rv, e_chk_rsp, e_rwr, e_rerr, e_mwr;
    logic [AW-1:0] e_maddr;
    logic [W-1:0]  e_mwd, e_rd;
    int            n_rd, n_wr, n_err;

    logic [W-1:0] mem [D];
    logic [W-1:0] ref_mem [D];

    mem_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int n);
`ifdef MEM_INITIATOR_STATS_EN
        return (n > 65535) ? 16'hFFFF : n[15:0];
`else
        return (n >= 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("req_ready", req_ready, e_rr);
            chk("mem_valid", mem_valid, e_mv);
            chk("mem_wr_rd", mem_wr_rd, e_mwr);
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_wdata", mem_wdata, e_mwd);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_chk_rsp) begin
                chk("rsp_wr", rsp_wr, e_rwr);
                chk("rsp_rdata", rsp_rdata, e_rd);
                chk("rsp_err", rsp_err, e_rerr);
            end
            chk("stat_rd", stat_rd, sat16(n_rd));
            chk("stat_wr", stat_wr, sat16(n_wr));
            chk("stat_err", stat_err, sat16(n_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one reset edge; afterwards every output must sit at its reset value and both memories are empty
    task automatic rst_pulse();
        res = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        rsp_ready = 1'b0;
        tick();
        res = 1'b0;
        e_rr = 1'b1; e_mv = 1'b0; e_mwr = 1'b0; e_maddr = '0; e_mwd = '0;
        e_rv = 1'b0; e_chk_rsp = 1'b1; e_rwr = 1'b0; e_rd = '0; e_rerr = 1'b0;
        n_rd = 0; n_wr = 0; n_err = 0;
        foreach (mem[i]) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
    endtask

    // lat: memory ready arrives in WAIT cycle lat-1 (0 or >TO means never); bp: cycles of rsp_ready=0
    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                       input int lat, input int bp, input int abort_at,
                       output logic [W-1:0] got_rd, output logic got_err, output logic got_rv);
        logic [W-1:0] rv, exp_rd;
        logic         err;
        got_rd = '0; got_err = 1'b0; got_rv = 1'b0; rv = '0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b0; mem_ready = 1'($urandom); mem_rdata = W'($urandom);
        e_rr = 1'b1; e_mv = 1'b0; e_rv = 1'b0; e_chk_rsp = 1'b0;
        tick();
        e_mwr = wr; e_maddr = a; e_mwd = wd; e_rr = 1'b0; e_mv = 1'b1;
        exp_rd = wr ? '0 : ref_mem[a];
        if (wr) ref_mem[a] = wd;
        if (mem_valid) begin
            rv = mem[mem_addr];
            if (mem_wr_rd) mem[mem_addr] = mem_wdata;
        end
        req_valid = 1'($urandom); req_wr = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = W'($urandom);
        mem_ready = 1'($urandom); mem_rdata = W'($urandom);
        tick();
        e_mv = 1'b0;
        for (int c = 0; c < TO; c++) begin
            if (c == abort_at) begin
                rst_pulse();
                return;
            end
            mem_ready = (c == lat - 1);
            mem_rdata = (c == lat - 1) ? rv : W'($urandom);
            req_valid = 1'($urandom);
            tick();
            if (c == lat - 1) break;
        end
        err = (lat <= 0 || lat > TO);
        e_rv = 1'b1; e_chk_rsp = 1'b1; e_rwr = wr; e_rerr = err; e_rd = err ? '0 : exp_rd;
        got_rd = rsp_rdata; got_err = rsp_err; got_rv = rsp_valid;
        for (int i = 0; i <= bp; i++) begin
            rsp_ready = (i == bp);
            mem_ready = 1'($urandom);
            mem_rdata = W'($urandom);
            req_valid = 1'b1;
            tick();
        end
        rsp_ready = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        e_rv = 1'b0; e_chk_rsp = 1'b0; e_rr = 1'b1;
        if (err) n_err++;
        else if (wr) n_wr++;
        else n_rd++;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         er, rvl;
        rst_pulse();
        armed = 1'b1;
        tick();

        txn(1'b0, 6'd63, '0, 1, 0, -1, rd, er, rvl);
        chk("rd63_unwritten", rd, 32'h0);

        txn(1'b1, 6'd5, 16'hBEEF, 1, 0, -1, rd, er, rvl);
        chk("wr5_rsp_valid", rvl, 32'h1);
        chk("wr5_rdata", rd, 32'h0);
        chk("wr5_err", er, 32'h0);

        txn(1'b0, 6'd5, '0, 1, 0, -1, rd, er, rvl);
        chk("rd5_data", rd, 32'hBEEF);
        chk("rd5_err", er, 32'h0);

        txn(1'b0, 6'd7, '0, 0, 0, -1, rd, er, rvl);
        chk("timeout_err", er, 32'h1);
        chk("timeout_rdata", rd, 32'h0);

        txn(1'b1, 6'd9, 16'h1234, 1, 0, -1, rd, er, rvl);
        chk("after_timeout_err", er, 32'h0);

        txn(1'b0, 6'd5, '0, TO, 5, -1, rd, er, rvl);
        chk("backpressure_rd5", rd, 32'hBEEF);

        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                req_valid = 1'b0;
                mem_ready = 1'($urandom);
                tick();
            end
            txn(1'($urandom), ($urandom_range(1, 0) == 1) ? AW'($urandom_range(7, 0)) : AW'($urandom),
                W'($urandom), $urandom_range(TO + 1, 0), $urandom_range(3, 0), -1, rd, er, rvl);
        end

        txn(1'b1, 6'd5, 16'hAAAA, 0, 0, 2, rd, er, rvl);
        txn(1'b0, 6'd5, '0, 1, 0, -1, rd, er, rvl);
        chk("rd5_after_reset", rd, 32'h0);

        rst_pulse();
        tick();
        for (int k = 0; k < 3; k++) txn(1'b1, AW'(k), W'(16'h100 + k), 1, 0, -1, rd, er, rvl);
        for (int k = 0; k < 2; k++) txn(1'b0, AW'(k), '0, 2, 1, -1, rd, er, rvl);
        txn(1'b0, 6'd3, '0, 0, 0, -1, rd, er, rvl);
`ifdef MEM_INITIATOR_STATS_EN
        chk("stat_wr_lit", stat_wr, 32'd3);
        chk("stat_rd_lit", stat_rd, 32'd2);
        chk("stat_err_lit", stat_err, 32'd1);
`else
        chk("stat_wr_lit", stat_wr, 32'd0);
        chk("stat_rd_lit", stat_rd, 32'd0);
        chk("stat_err_lit", stat_err, 32'd0);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator for the single-port memory request interface: valid, wr_rd, addr, wdata, rdata, ready.
- Accepts one request at a time from an upstream valid/ready request port.
- Issues a single-cycle memory strobe and waits for the memory's registered ready.
- Returns write-ack or read data on a backpressured response port; a ready timeout flags an error and recovers.

Parameters:
- WIDTH, 16, data width; matches the memory's WIDTH.
- DEPTH, 64, memory depth.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 8, max WAIT cycles without mem_ready before error; must be ≥2.

Ports:
- clk  input  1  clock
- res  input  1  synchronous active-high reset
- req_valid  input  1  upstream request present
- req_ready  output  1  request accepted this cycle when req_valid & req_ready
- req_wr  input  1  1=write, 0=read
- req_addr  input  ADDR_WIDTH  request address
- req_wdata  input  WIDTH  write data
- mem_valid  output  1  strobe to memory (memory valid)
- mem_wr_rd  output  1  to memory wr_rd
- mem_addr  output  ADDR_WIDTH  to memory addr
- mem_wdata  output  WIDTH  to memory wdata
- mem_rdata  input  WIDTH  from memory rdata
- mem_ready  input  1  from memory ready
- rsp_valid  output  1  response present
- rsp_ready  input  1  downstream accepts response
- rsp_wr  output  1  echo of request type
- rsp_rdata  output  WIDTH  read data; 0 for writes and errors
- rsp_err  output  1  timeout occurred
- stat_rd, stat_wr, stat_err  output  16 each  counters (see Optional Feature)

Behaviour:
- Interface: one clock clk; reset res is synchronous and active-high.
- Reset: state=IDLE; req_ready=1; mem_valid=0; mem_wr_rd=0; mem_addr=0; mem_wdata=0; rsp_valid=0; rsp_wr=0; rsp_rdata=0; rsp_err=0; timeout counter=0; stats=0.
- Reset mid-operation aborts any transaction: no response is produced, and mem_valid is 0 the cycle after the reset edge.
- All outputs are registered. req_ready is high only in IDLE (combinational decode of the state register is permitted).
- IDLE: on req_valid, latch req_wr/req_addr/req_wdata into mem_wr_rd/mem_addr/mem_wdata, set mem_valid=1, go ISSUE.
- ISSUE (exactly 1 cycle): mem_valid=1. Next edge: mem_valid=0, clear the timeout counter, go WAIT.
  - mem_valid is never high for 2 consecutive cycles, so no double write.
- WAIT: mem_valid=0; mem_addr, mem_wdata and mem_wr_rd are held.
  - If mem_ready: rsp_valid=1, rsp_wr=mem_wr_rd, rsp_err=0, rsp_rdata = mem_rdata for a read, else 0. Go RESP.
  - Else increment the counter. When counter==TIMEOUT-1 without mem_ready: rsp_valid=1, rsp_err=1, rsp_rdata=0, go RESP.
  - A mem_ready arriving on the same cycle as the timeout wins (success).
- Nominal latency: request accept → mem_valid at the next edge; with a responder that answers in 1 cycle, rsp_valid is high 3 cycles after accept.
- RESP: hold every rsp_* output stable while rsp_ready=0. On rsp_ready: rsp_valid=0, go IDLE; the next request is accepted ≥1 cycle later (no same-cycle turnaround).
- A stray mem_ready in IDLE/ISSUE/RESP is ignored.
- Address wrap is not handled here; addresses are passed through verbatim.

Optional Feature:
- Macro MEM_INITIATOR_STATS_EN.
- Defined: stat_rd, stat_wr and stat_err are 16-bit saturating counters (hold at 16'hFFFF), each incremented on the RESP→IDLE handshake of a successful read, a successful write, or an error respectively. Cleared by res.
- Undefined: the ports remain but are tied to 0, and no counter flops are generated.

Decomposition:
- Package mem_if_pkg holds:
  - the typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  - the constants MEM_WR=1'b1 and MEM_RD=1'b0;
  - a packed struct mem_req_t {wr, addr, wdata} parameterised via the package's default WIDTH/ADDR_WIDTH.
- Sub-module mem_init_timeout: a loadable down-counter with an expired flag. Natural split, optional.

Test Plan:
- Bench pairs the initiator with the memory responder. Write addr 5, data 16'hBEEF → mem_valid high exactly 1 cycle with wr_rd=1; rsp_valid 3 cycles after accept, rsp_wr=1, rsp_err=0, rsp_rdata=0.
- Read addr 5 after that write → rsp_rdata=16'hBEEF, rsp_err=0. Read an unwritten addr 63 after reset → 16'h0000.
- mem_ready tied 0, TIMEOUT=8 → rsp_err=1 with rsp_rdata=0, then IDLE; the next request completes normally.
- rsp_ready held 0 for 5 cycles → rsp_* stable and req_ready=0 throughout; req_valid held high is not accepted until 1 cycle after the handshake.
- res asserted during WAIT → next cycle all outputs at reset values, no rsp_valid; a subsequent read returns 0 because memory is also reset.
- With MEM_INITIATOR_STATS_EN: 3 writes, 2 reads, 1 timeout → stat_wr=3, stat_rd=2, stat_err=1. Without it, all stats read 0.
